// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell stepped LSB first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);
  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .C_in  (carry),
    .S     (fa_s),
    .C_out (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= c_in;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB here
            c_out <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= carry ^ fa_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8).
// Checks ovf as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;
  int dones  = 0;

  typedef struct packed {
    logic         ov;
    logic         co;
    logic [W-1:0] s;
  } exp_t;

  exp_t q[$];
  exp_t e;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf   (ovf),
`endif
    .c_out (c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic ci);
    exp_t m;
    logic [W:0] t;
    t    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    m.s  = t[W-1:0];
    m.co = t[W];
    m.ov = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        dones++;
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
          chk("ovf", 32'(ovf), 32'(e.ov));
`endif
        end
      end
    end
  end

  task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, output int lat, output int bcy);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    c_in  = ci;
    q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcy   = 0;
    while (!done && lat < 50) begin
      if (busy) bcy++;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  int lat, bcy, d0, n;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_c_out", 32'(c_out), 0);
    rst_n = 1'b1;

    // basic add with latency and busy width
    run_add(8'h5A, 8'h3C, 1'b0, lat, bcy);
    chk("lat", 32'(lat), 9);
    chk("busy_cycles", 32'(bcy), 8);
    run_add(8'hFF, 8'h01, 1'b0, lat, bcy);
    run_add(8'hFF, 8'hFF, 1'b1, lat, bcy);
    chk("lat2", 32'(lat), 9);

    // start during RUN is ignored
    @(negedge clk);
    #1 d0 = dones;
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    c_in  = 1'b0;
    q.push_back(model(8'h01, 8'h02, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("one_done", 32'(dones - d0), 1);
    chk("q_empty_ign", 32'(q.size()), 0);

    // reset mid-RUN aborts
    @(negedge clk);
    #1 d0 = dones;
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h44;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_c_out", 32'(c_out), 0);
    repeat (20) @(negedge clk);
    #1 chk("abort_no_done", 32'(dones - d0), 0);
    run_add(8'h12, 8'h34, 1'b1, lat, bcy);
    chk("post_abort_lat", 32'(lat), 9);

    // start held high: back-to-back adds
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    c_in  = 1'b0;
    q.push_back(model(8'h10, 8'h20, 1'b0));
    q.push_back(model(8'h80, 8'h80, 1'b0));
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first", 32'(n), 8);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_reaccept", 32'(busy), 1);
    n = 2;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_gap", 32'(n), 10);

    // signed overflow cases
    run_add(8'h7F, 8'h01, 1'b0, lat, bcy);
    run_add(8'hFF, 8'h01, 1'b0, lat, bcy);
    run_add(8'h80, 8'h80, 1'b0, lat, bcy);
    run_add(8'h00, 8'h00, 1'b1, lat, bcy);

    repeat (15) @(negedge clk);
    chk("q_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
